// File: rtl/io_bridge_pkg.sv
// Shared definitions for the miniRV IO bridge: address map, register select and 7-seg font.
// Latency: n/a (constants and a pure combinational decode helper).
// Backpressure: n/a.
//
// Contents:
//   IO_BASE      upper 20 address bits that select the peripheral window
//   *_OFF        byte offsets of the peripheral registers inside the window
//   io_reg_e     which peripheral register a word offset selects
//   SEG_PAT      active-low {dp,g,f,e,d,c,b,a} glyphs for hex digits 0..F
//   io_decode()  word offset -> io_reg_e
package miniRV_io_pkg;

  localparam logic [19:0] IO_BASE    = 20'hFFFFF;

  localparam logic [11:0] DIGITS_OFF = 12'h000;
  localparam logic [11:0] TIMER_OFF  = 12'h020;
  localparam logic [11:0] LED_OFF    = 12'h060;
  localparam logic [11:0] SW_OFF     = 12'h070;

  typedef enum logic [2:0] {
    REG_DIGITS,
    REG_TIMER,
    REG_LED,
    REG_SW,
    REG_NONE
  } io_reg_e;

  // Entry n is the glyph for hex digit n; the dp bit (bit 7) is high in every entry.
  localparam logic [15:0][7:0] SEG_PAT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E d C
    8'h83, 8'h88, 8'h90, 8'h80,   // b A 9 8
    8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
    8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
  };

  // Takes the word offset (byte offset bits [11:2]) so sub-word address bits never matter.
  function automatic io_reg_e io_decode(input logic [9:0] word_off);
    io_reg_e r;
    r = REG_NONE;
    case (word_off)
      DIGITS_OFF[11:2]: r = REG_DIGITS;
      TIMER_OFF[11:2]:  r = REG_TIMER;
      LED_OFF[11:2]:    r = REG_LED;
      SW_OFF[11:2]:     r = REG_SW;
      default:          r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/io_bridge_if.sv
// CPU data-memory bus as seen by the IO bridge, plus the pass-through port to data_mem.
// Latency: n/a (wires only); load data is combinational end to end.
// Backpressure: none; every access completes in the cycle it is presented.
//
// Signals:
//   cpu_adr/cpu_we/cpu_wdin  byte address, store enable, store data from the core
//   cpu_rd                   load data back to the core
//   dm_adr/dm_we/dm_wdin     word address, write enable, write data to data_mem
//   dm_rd                    read data from data_mem
// Modports:
//   slave   the bridge side
//   master  the core + data_mem side (used by the bench)
interface io_bridge_if;

  logic [31:0] cpu_adr;
  logic        cpu_we;
  logic [31:0] cpu_wdin;
  logic [31:0] cpu_rd;
  logic [15:0] dm_adr;
  logic        dm_we;
  logic [31:0] dm_wdin;
  logic [31:0] dm_rd;

  modport slave (
    input  cpu_adr, cpu_we, cpu_wdin, dm_rd,
    output cpu_rd, dm_adr, dm_we, dm_wdin
  );

  modport master (
    output cpu_adr, cpu_we, cpu_wdin, dm_rd,
    input  cpu_rd, dm_adr, dm_we, dm_wdin
  );

endinterface

// File: rtl/io_bridge_seg_scan.sv
// Eight-digit multiplexed seven-segment scanner driven from a 32-bit hex word.
// Latency: seg_en/seg_dn are registered one cycle behind the current digit index and digits.
// Backpressure: none; free-running.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   digits       eight hex nibbles, nibble i shown on digit i
//   seg_en       active-low digit enables (registered)
//   seg_dn       active-low segments {dp,g,f,e,d,c,b,a} (registered)
module seg_scan
  import miniRV_io_pkg::*;
#(
  parameter int SCAN_DIV = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] digits,
  output logic [7:0]  seg_en,
  output logic [7:0]  seg_dn
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  logic [CW-1:0] scan_cnt;
  logic [2:0]    idx;
  logic [3:0]    nib;

  assign nib = digits[{idx, 2'b00} +: 4];

  // Outputs follow idx/digits by one edge, so a DIGITS store shows up on the
  // active digit at the edge after it lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
      seg_en   <= 8'hFF;
      seg_dn   <= 8'hFF;
    end else begin
      if (scan_cnt == CNT_MAX) begin
        scan_cnt <= '0;
        idx      <= idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + CW'(1);
      end
      seg_en <= ~(8'b1 << idx);
      seg_dn <= {1'b1, SEG_PAT[nib][6:0]};
    end
  end

endmodule

// File: rtl/io_bridge.sv
// Splits miniRV data accesses between data RAM and a small MMIO block (LED, SW, TIMER, DIGITS).
// Latency: loads return combinationally in the same cycle; stores and peripheral state update at clk.
// Backpressure: none; every access completes in the cycle it is presented.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   bus (slave)        core data port and data_mem port, see io_bridge_if
//   sw                 board switches, asynchronous, synchronised with two flops
//   led                board LEDs (registered)
//   seg_en, seg_dn     seven-segment digit enables and segments, active-low (registered)
module io_bridge
  import miniRV_io_pkg::*;
#(
  parameter int SCAN_DIV  = 20000,
  parameter int TIMER_DIV = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  io_bridge_if.slave   bus,
  input  logic [23:0]  sw,
  output logic [23:0]  led,
  output logic [7:0]   seg_en,
  output logic [7:0]   seg_dn
);

  // A single-value prescaler still needs one bit of storage.
  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TIMER_DIV - 1);

  logic          io_sel;
  io_reg_e       reg_sel;
  logic          wr_digits;
  logic          wr_timer;
  logic          wr_led;
  logic [31:0]   io_rd;

  logic [31:0]   digits;
  logic [31:0]   timer;
  logic [PW-1:0] presc;
  logic [23:0]   sw_meta;
  logic [23:0]   sw_sync;

  // Byte-lane bits are never looked at; only word accesses exist.
  logic unused_adr;
  assign unused_adr = ^bus.cpu_adr[1:0];

  // ---------------- decode ----------------
  assign io_sel  = (bus.cpu_adr[31:12] == IO_BASE);
  assign reg_sel = io_decode(bus.cpu_adr[11:2]);

  assign wr_digits = bus.cpu_we & io_sel & (reg_sel == REG_DIGITS);
  assign wr_timer  = bus.cpu_we & io_sel & (reg_sel == REG_TIMER);
  assign wr_led    = bus.cpu_we & io_sel & (reg_sel == REG_LED);

  // ---------------- data RAM path ----------------
  // dm_we is kept purely combinational so RAM gating never depends on bridge state.
  assign bus.dm_adr  = bus.cpu_adr[17:2];
  assign bus.dm_wdin = bus.cpu_wdin;
  assign bus.dm_we   = bus.cpu_we & ~io_sel;

  // ---------------- load mux ----------------
  always_comb begin
    io_rd = '0;
    case (reg_sel)
      REG_DIGITS: io_rd = digits;
      REG_TIMER:  io_rd = timer;
      REG_LED:    io_rd = {8'h00, led};
      REG_SW:     io_rd = {8'h00, sw_sync};
      default:    io_rd = '0;
    endcase
  end

  assign bus.cpu_rd = io_sel ? io_rd : bus.dm_rd;

  // ---------------- writable registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led    <= '0;
      digits <= '0;
    end else begin
      if (wr_led)    led    <= bus.cpu_wdin[23:0];
      if (wr_digits) digits <= bus.cpu_wdin;
    end
  end

  // ---------------- timer ----------------
  // A software write beats the tick and restarts the prescale period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
      presc <= '0;
    end else if (wr_timer) begin
      timer <= bus.cpu_wdin;
      presc <= '0;
    end else if (presc == PRESC_MAX) begin
      timer <= timer + 32'd1;
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // ---------------- switch synchroniser ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  // ---------------- seven-segment scanner ----------------
  seg_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_seg_scan (
    .clk    (clk),
    .rst_n  (rst_n),
    .digits (digits),
    .seg_en (seg_en),
    .seg_dn (seg_dn)
  );

endmodule
